// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single arithmetic cell reused every cycle by the
// serial datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are loaded on start, then one bit per
// cycle passes LSB-first through a single full adder with the carry held in a
// flop. The result assembles from the MSB side so it ends up aligned after
// WIDTH cycles. Subtraction is a + ~b + 1: b is inverted on load and the
// carry flop is seeded with 1.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1; keep at least one bit.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res_q;
  logic [CW-1:0]    count;
  logic             carry, cout_q, ovf_q;
  logic             fa_s, fa_c;
  logic             load, last_bit;

  assign last_bit = (count == LAST);
  assign result   = res_q;
  assign cout     = cout_q;
  assign ovf      = ovf_q;

  full_adder u_cell (
    .x (sa[0]),
    .y (sb[0]),
    .z (carry),
    .s (fa_s),
    .c (fa_c)
  );

  // State register; reset dominates everything including a coincident start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, per-bit shift, and flag capture on the final bit.
  // Flags are only rewritten at the end of an operation, so they keep their
  // previous value while a new one is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res_q  <= '0;
      count  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= sub ? ~b : b;
      carry <= sub;
      count <= '0;
    end else if (busy) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res_q <= {fa_s, res_q[WIDTH-1:1]};
      carry <= fa_c;
      count <= count + 1'b1;
      if (last_bit) begin
        // Signed overflow: carry into the MSB differs from carry out of it.
        cout_q <= fa_c;
        ovf_q  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vectors, random
// add/sub against an integer-arithmetic reference, start-while-busy, reset
// mid-operation and back-to-back operations.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rsub, output logic [W-1:0] r,
                                    output logic co, output logic ov);
    int ua, ub, s1, s2, sr;
    ua = int'(ra);
    ub = int'(rb);
    s1 = int'($signed(ra));
    s2 = int'($signed(rb));
    if (rsub) begin
      r  = W'(ua - ub);
      co = (ua >= ub);
      sr = s1 - s2;
    end else begin
      r  = W'(ua + ub);
      co = (ua + ub) > 255;
      sr = s1 + s2;
    end
    ov = (sr > 127) || (sr < -128);
  endfunction

  // Issue one operation and wait for done. lat counts cycles from the start
  // edge to the done cycle; bcnt counts cycles with busy high.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                       output int lat, output int bcnt, output logic tmo);
    int n;
    @(negedge clk);
    a = oa; b = ob; sub = osub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom;
    n = 1; bcnt = 0; tmo = 1'b1; lat = 0;
    while (n <= 40) begin
      if (busy) bcnt++;
      if (done) begin
        lat = n; tmo = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic osub);
    int lat, bcnt;
    logic tmo, eco, eov;
    logic [W-1:0] er;
    ref_model(oa, ob, osub, er, eco, eov);
    do_op(oa, ob, osub, lat, bcnt, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL %s timeout waiting for done", nm);
    end else if (result !== er || cout !== eco || ovf !== eov) begin
      errors++;
      $display("FAIL %s a=%0d b=%0d sub=%0d got r=%h co=%b ov=%b want r=%h co=%b ov=%b",
               nm, oa, ob, osub, result, cout, ovf, er, eco, eov);
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b r=%h co=%b ov=%b want all 0",
               busy, done, result, cout, ovf);
    end
    // rst and start together: reset wins, the start is lost.
    a = 8'd1; b = 8'd2; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (12) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_with_start busy/done cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_directed();
    int lat, bcnt;
    logic tmo;
    logic [W-1:0] va[5] = '{8'd100, 8'd200, 8'd5, 8'h7F, 8'h80};
    logic [W-1:0] vb[5] = '{8'd27, 8'd100, 8'd9, 8'd1, 8'd1};
    logic         vs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] vr[5] = '{8'd127, 8'd44, 8'hFC, 8'h80, 8'h7F};
    logic         vc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         vo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], lat, bcnt, tmo);
      checks++;
      if (tmo || result !== vr[i] || cout !== vc[i] || ovf !== vo[i]) begin
        errors++;
        $display("FAIL directed%0d tmo=%b r=%h co=%b ov=%b want r=%h co=%b ov=%b",
                 i, tmo, result, cout, ovf, vr[i], vc[i], vo[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 9 || bcnt != 8) begin
          errors++;
          $display("FAIL timing latency=%0d busy_cycles=%0d want 9 and 8", lat, bcnt);
        end
      end
      // done must be a single-cycle pulse and busy low once it ends.
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse%0d done=%b busy=%b after pulse want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    check_op("sub_zero", 8'h00, 8'h00, 1'b1);
    check_op("sub_min", 8'h00, 8'h80, 1'b1);
    check_op("add_ff", 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_start_ignored();
    int n, pulses;
    @(negedge clk);
    a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (n = 1; n <= 30; n++) begin
      if (n == 3) begin a = 8'd1; b = 8'd1; sub = 1'b1; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (done) begin
        pulses++;
        checks++;
        if (result !== 8'd30 || n != 9) begin
          errors++;
          $display("FAIL ignore_start r=%0d at cycle %0d want 30 at 9", result, n);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignore_start done pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, pulses;
    // Leave cout/ovf set so the reset clearing them is observable.
    check_op("pre_abort", 8'h80, 8'h01, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n < 4; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b r=%h co=%b ov=%b want all 0",
               busy, done, result, cout, ovf);
    end
    pulses = 0;
    repeat (15) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_done busy/done cycles=%0d want 0", pulses);
    end
    check_op("after_abort", 8'd3, 8'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic tmo;
    // do_op starts on the cycle right after done, the fastest legal cadence.
    do_op(8'd50, 8'd60, 1'b0, lat, bcnt, tmo);
    do_op(8'd90, 8'd33, 1'b1, lat, bcnt, tmo);
    checks++;
    if (tmo || lat != 9 || result !== 8'd57 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back tmo=%b lat=%0d r=%0d co=%b ov=%b want 9 57 1 0",
               tmo, lat, result, cout, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
